// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single cell.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, res_next;
  logic             borrow_reg;
  logic             d_bit, bout_bit, last_bit, accept;

  full_subtractor u_cell (
    .x    (a_sh_reg[0]),
    .y    (b_sh_reg[0]),
    .bin  (borrow_reg),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign accept   = (state_reg == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // New result bits enter at the MSB so the LSB-first stream lands in place.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = d_bit;
    end else begin : g_res_multi
      assign res_next = {d_bit, res_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      res_reg    <= res_next;
      borrow_reg <= bout_bit;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign diff   = res_reg;
  assign borrow = borrow_reg;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_reg, b_msb_reg, ovf_reg;

  // Operand MSBs are kept aside because the shift registers lose them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if ((state_reg == RUN) && last_bit) begin
      ovf_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
    end
  end

  assign ovf = ovf_reg;
`endif

endmodule
